// File: rtl/key_if.sv
// Bundles the raw key inputs and the conditioned outputs of key_conditioner.
// The master side is the conditioner and the slave side is the consumer.
interface key_if #(
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  a;
    logic [N-1:0]  pulse;
    logic [N-1:0]  level;
    logic          key_valid;
    logic [IW-1:0] key_idx;

    modport master (
        input  a,
        output pulse,
        output level,
        output key_valid,
        output key_idx
    );

    modport slave (
        output a,
        input  pulse,
        input  level,
        input  key_valid,
        input  key_idx
    );
endinterface

// File: rtl/key_conditioner.sv
// Per-channel synchronise, debounce and press-pulse generation for N keys.
// Defining KEY_CONDITIONER_REPEAT_EN adds auto-repeat pulses while a key is held.
//
// state | meaning
// IDLE  | debounced level is 0, waiting for an accepted rise
// HELD  | debounced level is 1, waiting for an accepted fall
module key_conditioner #(
    parameter int N             = 4,
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 8
) (
    input logic   clk_sys_i,
    input logic   rst_i,
    key_if.master kif
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(DB_CYCLES + 1);

    typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_e;

    logic [N-1:0]  sync1_q, sync2_q;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];
    state_e        state_q [N];
    state_e        state_d [N];
    logic [N-1:0]  level;
    logic [N-1:0]  press;
    logic [N-1:0]  rpt_fire;
    logic [N-1:0]  pulse_d, pulse_q;
    logic [IW-1:0] key_idx;

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            pulse_q <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i]   <= '0;
                state_q[i] <= IDLE;
            end
        end else begin
            sync1_q <= kif.a;
            sync2_q <= sync1_q;
            pulse_q <= pulse_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i]   <= cnt_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    // The counter never holds DB_CYCLES: reaching it toggles the state and clears.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            level[i]   = (state_q[i] == HELD);
            cnt_d[i]   = '0;
            state_d[i] = state_q[i];
            if (sync2_q[i] != level[i]) begin
                if (cnt_q[i] >= CW'(DB_CYCLES - 1)) begin
                    state_d[i] = (state_q[i] == IDLE) ? HELD : IDLE;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            press[i] = (state_q[i] == IDLE) && (state_d[i] == HELD);
        end
        pulse_d = press | rpt_fire;
    end

`ifdef KEY_CONDITIONER_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX);

    logic [RW-1:0] rpt_q [N];
    logic [RW-1:0] rpt_d [N];

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++) rpt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) rpt_q[i] <= rpt_d[i];
        end
    end

    // Down-counter only runs while staying in HELD, so a release on the due edge wins.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            rpt_fire[i] = 1'b0;
            rpt_d[i]    = '0;
            if (press[i]) begin
                rpt_d[i] = RW'(REPEAT_DELAY - 1);
            end else if (state_q[i] == HELD && state_d[i] == HELD) begin
                if (rpt_q[i] == '0) begin
                    rpt_fire[i] = 1'b1;
                    rpt_d[i]    = RW'(REPEAT_PERIOD - 1);
                end else begin
                    rpt_d[i] = rpt_q[i] - RW'(1);
                end
            end
        end
    end
`else
    assign rpt_fire = '0;
`endif

    always_comb begin
        key_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pulse_q[i]) key_idx = IW'(i);
        end
    end

    assign kif.pulse     = pulse_q;
    assign kif.level     = level;
    assign kif.key_valid = |pulse_q;
    assign kif.key_idx   = key_idx;
endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: expected pulses queued up front, a monitor
// pops them as key_valid appears; level/reset values are checked directly.
module tb_key_conditioner;
    logic clk_sys = 1'b0;
    logic rst     = 1'b1;
    int   edge_n  = 0;
    int   checks  = 0;
    int   fails   = 0;
    bit   done    = 1'b0;

    typedef struct {
        int         cyc;
        logic [3:0] p;
        logic [1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    key_if #(.N(4)) kif ();

    key_conditioner #(
        .N(4), .DB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut (
        .clk_sys_i(clk_sys),
        .rst_i    (rst),
        .kif      (kif)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) edge_n <= edge_n + 1;

    task automatic push(input int cyc, input logic [3:0] p, input logic [1:0] idx);
        exp_t e;
        e.cyc = cyc; e.p = p; e.idx = idx;
        exp_q.push_back(e);
    endtask

    // Returns at the falling edge just before rising edge k.
    task automatic goto(input int k);
        while (edge_n < k - 1) @(negedge clk_sys);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (after edge %0d)", name, act, exp, edge_n);
        end
    endtask

    always @(negedge clk_sys) begin
        if (!done) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
                mon_e = exp_q.pop_front();
                checks++;
                fails++;
                $display("FAIL missed_pulse: expected pulse=%b after edge %0d was not observed", mon_e.p, mon_e.cyc);
            end
            if (kif.key_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse: got pulse=%b idx=%0d after edge %0d, expected none", kif.pulse, kif.key_idx, edge_n);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != edge_n || kif.pulse !== mon_e.p || kif.key_idx !== mon_e.idx) begin
                        fails++;
                        $display("FAIL pulse_event: got pulse=%b idx=%0d edge=%0d expected pulse=%b idx=%0d edge=%0d",
                                 kif.pulse, kif.key_idx, edge_n, mon_e.p, mon_e.idx, mon_e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        kif.a = 4'b0000;
        push(15, 4'b0001, 2'd0);
        push(36, 4'b0001, 2'd0);
        push(45, 4'b0010, 2'd1);
`ifdef KEY_CONDITIONER_REPEAT_EN
        push(56, 4'b0001, 2'd0);
        push(64, 4'b0001, 2'd0);
`endif
        push(75, 4'b1100, 2'd2);
        push(105, 4'b0001, 2'd0);
`ifdef KEY_CONDITIONER_REPEAT_EN
        push(125, 4'b0001, 2'd0);
        push(133, 4'b0001, 2'd0);
        push(141, 4'b0001, 2'd0);
        push(149, 4'b0001, 2'd0);
        push(157, 4'b0001, 2'd0);
`endif

        goto(3);
        chk("reset_level", 32'(kif.level), 32'h0);
        chk("reset_pulse", 32'(kif.pulse), 32'h0);
        chk("reset_valid", 32'(kif.key_valid), 32'h0);
        chk("reset_idx", 32'(kif.key_idx), 32'h0);
        rst = 1'b0;

        goto(10); kif.a[0] = 1'b1;
        goto(12); kif.a[1] = 1'b1;
        goto(15);
        chk("level0_before_accept", 32'(kif.level[0]), 32'h0);
        kif.a[1] = 1'b0;
        goto(16); chk("level0_after_accept", 32'(kif.level[0]), 32'h1);
        goto(21); chk("glitch_level1", 32'(kif.level[1]), 32'h0);

        goto(30); rst = 1'b1;
        goto(31);
        chk("midrst_level", 32'(kif.level), 32'h0);
        chk("midrst_pulse", 32'(kif.pulse), 32'h0);
        chk("midrst_valid", 32'(kif.key_valid), 32'h0);
        chk("midrst_idx", 32'(kif.key_idx), 32'h0);
        rst = 1'b0;
        goto(36); chk("postrst_level0_early", 32'(kif.level[0]), 32'h0);
        goto(37); chk("postrst_level0", 32'(kif.level[0]), 32'h1);

        goto(40); kif.a[1] = 1'b1;
        goto(48); kif.a[1] = 1'b0;
        goto(60); kif.a[0] = 1'b0;
        goto(65); chk("fall_level0_before", 32'(kif.level[0]), 32'h1);
        goto(66); chk("fall_level0_after", 32'(kif.level[0]), 32'h0);

        goto(70); kif.a[3:2] = 2'b11;
        goto(76); chk("dual_level", 32'(kif.level), 32'hC);
        goto(80); kif.a[3:2] = 2'b00;

        goto(100); kif.a[0] = 1'b1;
        goto(160); kif.a[0] = 1'b0;
        goto(166); chk("long_hold_release", 32'(kif.level), 32'h0);

        goto(200);
        done = 1'b1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
